alu_regfile_datapath: RTL and testbench
=======================================

Name: alu_regfile_datapath

Overview:
Execution datapath of the small 16-bit processor. It combines an 8-entry x 16-bit register file with two asynchronous read ports and one synchronous write port, a combinational ALU fed by the two read ports, and a registered zero-status flag. The processor's decode logic drives the register addresses, the opcode, the write enable and the write data. It consumes data_a, alu_result and zero_flag for write-back, output and branching.

Parameters:
DATA_W, 16, datapath and register width in bits
ADDR_W, 3, register address width; register count = 2**ADDR_W (8)

Ports:
clk  input  1  system clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
address_a  input  ADDR_W  read port A address; also the write address
address_b  input  ADDR_W  read port B address
write_enable  input  1  register write strobe, sampled at rising clk
write_data  input  DATA_W  data written to register[address_a]
opcode  input  4  ALU operation select (instruction[15:12])
data_a  output  DATA_W  register[address_a], combinational
data_b  output  DATA_W  register[address_b], combinational
alu_result  output  DATA_W  ALU result, combinational
alu_zero  output  1  1 when alu_result == 0, combinational
zero_flag  output  1  registered zero status flag

Behaviour:
Reset:
- rst_n low clears all registers and zero_flag to 0 immediately, without waiting for a clock edge.
- Writes are blocked while rst_n is low.
- Because outputs are combinational, during reset data_a = data_b = 0 and alu_result follows the opcode applied to zeros.

Register file:
- 2**ADDR_W registers. Register 0 is an ordinary writable register, not hardwired to zero.
- Write: at rising clk, if rst_n high and write_enable = 1, register[address_a] <= write_data.
- Reads are asynchronous: data_a and data_b follow the addresses and register contents combinationally.
- Read-during-write has no bypass. data_a/data_b show the old value until the write edge and the new value right after it.
- address_a == address_b returns the same value on both ports.

ALU (combinational, zero latency, a = data_a, b = data_b):
- 0010 ADD: (a + b) mod 2^16; carry is discarded.
- 0011 SUB: (a - b) mod 2^16; borrow wraps, e.g. 0 - 1 = 16'hFFFF.
- 0100 AND: a & b
- 0101 OR: a | b
- 0110 XOR: a ^ b
- 0111 NOT: ~a
- 1001 SHL: a << b[3:0], zero fill
- 1010 SHR: a >> b[3:0], logical, zero fill
- All other opcodes (0000, 0001, 1000, 1011, 1100-1111): pass-through, alu_result = a.
- alu_zero = (alu_result == 0) for every opcode.

Zero flag:
- At rising clk, if opcode == 0011 (SUB) and write_enable = 1, zero_flag <= alu_zero, computed from pre-edge register values.
- zero_flag holds its value under all other conditions, including non-SUB opcodes and SUB with write_enable = 0.

Simultaneous events:
- SUB with write-back to address_a updates the register and zero_flag on the same edge.
- Both updates use operands sampled before the edge.
- Reset asserted mid-operation overrides any pending write.

No handshakes. Every result is valid in the same cycle its inputs are stable.

Test Plan:
- Reset: hold rst_n = 0 after writing r3 = 16'h1234, then release -> r0..r7 read 0, zero_flag = 0, the prior write is lost. Assert rst_n low between clock edges -> registers clear without waiting for an edge.
- Write/read: write r1 = 5 and r2 = 3, set address_a = 1, address_b = 2 -> data_a = 5, data_b = 3. Write r7 = 16'hFFFF, read r7 on both ports -> 16'hFFFF on both.
- ADD wrap: r1 = 16'hFFFF, r2 = 2, opcode 0010, write_data = alu_result, write_enable = 1 -> alu_result = 16'h0001 before the edge, r1 = 1 after the edge, zero_flag unchanged.
- SUB and flag: r1 = 7, r2 = 7, opcode 0011, write_enable = 1 -> alu_zero = 1, r1 = 0 and zero_flag = 1 after the edge. Then r1 = 0, r2 = 1, SUB -> result 16'hFFFF and zero_flag = 0.
- Flag hold: set zero_flag = 1, then ADD producing 0, then SUB with write_enable = 0 producing nonzero -> zero_flag stays 1 throughout.
- Logic/shift/pass: a = 16'h00F0, b = 16'h0F0F:
  - AND -> 0000
  - OR -> 0FFF
  - XOR -> 0FFF
  - NOT -> FF0F
  - SHL (b[3:0] = F) -> 0000
  - opcode 1111 -> 00F0
  - Write with write_enable = 0 leaves the register unchanged.

Source files
------------

// File: rtl/alu_regfile_datapath_if.sv
// Bus between the decode logic and the execution datapath: register
// addresses, write strobe/data and opcode in; operands, ALU result and
// zero status out.
interface alu_regfile_datapath_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic [ADDR_W-1:0] address_a;
    logic [ADDR_W-1:0] address_b;
    logic              write_enable;
    logic [DATA_W-1:0] write_data;
    logic [3:0]        opcode;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              zero_flag;

    // Decode side: drives addresses, control and write data
    modport master (
        output address_a, address_b, write_enable, write_data, opcode,
        input  data_a, data_b, alu_result, alu_zero, zero_flag
    );

    // Datapath side: consumes control, returns operands and results
    modport slave (
        input  address_a, address_b, write_enable, write_data, opcode,
        output data_a, data_b, alu_result, alu_zero, zero_flag
    );
endinterface

// File: rtl/alu_regfile_datapath.sv
// Execution datapath: 2**ADDR_W x DATA_W register file (two asynchronous
// read ports, one synchronous write port addressed by address_a), a
// combinational ALU on the two read ports, and a zero flag that is only
// updated by a SUB that also writes back.
module alu_regfile_datapath #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_regfile_datapath_if.slave  bus
);
    localparam int REG_COUNT = 2 ** ADDR_W;

    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHL = 4'b1001;
    localparam logic [3:0] OP_SHR = 4'b1010;

    logic [DATA_W-1:0] regs_r [REG_COUNT];
    logic              zero_flag_r;
    logic [DATA_W-1:0] data_a_s;
    logic [DATA_W-1:0] data_b_s;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_zero_s;
    logic [3:0]        shamt_s;
    logic              flag_update_s;

    // Register file write port; reset clears every entry and blocks writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (bus.write_enable) begin
            regs_r[bus.address_a] <= bus.write_data;
        end
    end

    // Zero flag captures the pre-edge ALU zero only on a writing SUB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_flag_r <= 1'b0;
        end else if (flag_update_s) begin
            zero_flag_r <= alu_zero_s;
        end
    end

    // Asynchronous read ports, no write bypass
    always_comb begin
        data_a_s = regs_r[bus.address_a];
        data_b_s = regs_r[bus.address_b];
    end

    // ALU: wrapping arithmetic, bitwise logic, 4-bit shifts, else pass-through
    always_comb begin
        alu_result_s = data_a_s;
        shamt_s      = data_b_s[3:0];
        case (bus.opcode)
            OP_ADD:  alu_result_s = data_a_s + data_b_s;
            OP_SUB:  alu_result_s = data_a_s - data_b_s;
            OP_AND:  alu_result_s = data_a_s & data_b_s;
            OP_OR:   alu_result_s = data_a_s | data_b_s;
            OP_XOR:  alu_result_s = data_a_s ^ data_b_s;
            OP_NOT:  alu_result_s = ~data_a_s;
            OP_SHL:  alu_result_s = data_a_s << shamt_s;
            OP_SHR:  alu_result_s = data_a_s >> shamt_s;
            default: alu_result_s = data_a_s;
        endcase
    end

    // Zero detect and flag-update qualifier
    always_comb begin
        alu_zero_s    = (alu_result_s == {DATA_W{1'b0}});
        flag_update_s = 1'b0;
        if ((bus.opcode == OP_SUB) && bus.write_enable) begin
            flag_update_s = 1'b1;
        end else begin
            flag_update_s = 1'b0;
        end
    end

    assign bus.data_a     = data_a_s;
    assign bus.data_b     = data_b_s;
    assign bus.alu_result = alu_result_s;
    assign bus.alu_zero   = alu_zero_s;
    assign bus.zero_flag  = zero_flag_r;

endmodule

// File: tb/tb_alu_regfile_datapath.sv
// Bench for alu_regfile_datapath: directed scenarios with literal
// expectations followed by random traffic, all checked every cycle
// against an arithmetic model of the register file, ALU and zero flag.
module tb_alu_regfile_datapath;
    localparam int DW = 16;
    localparam int AW = 3;

    localparam int K_NONE = -1;
    localparam int K_A    = 0;
    localparam int K_B    = 1;
    localparam int K_R    = 2;
    localparam int K_Z    = 3;
    localparam int K_F    = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    alu_regfile_datapath_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    alu_regfile_datapath #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [15:0] mreg [8] = '{default: 16'd0};
    logic        mzf      = 1'b0;

    logic        lit_valid = 1'b0;
    int          lit_kind  = K_NONE;
    logic [15:0] lit_val   = 16'd0;
    string       lit_name  = "";
    logic        cmp_en    = 1'b0;

    // Reference ALU from the opcode table, in plain integer arithmetic
    function automatic logic [15:0] model_alu(input logic [3:0] op,
                                              input logic [15:0] a,
                                              input logic [15:0] b);
        int unsigned ua;
        int unsigned ub;
        int unsigned s;
        int unsigned r;
        ua = 32'(a);
        ub = 32'(b);
        s  = ub % 32'd16;
        case (op)
            4'd2:    r = (ua + ub) % 32'd65536;
            4'd3:    r = (ua + 32'd65536 - ub) % 32'd65536;
            4'd4:    r = ua & ub;
            4'd5:    r = ua | ub;
            4'd6:    r = ua ^ ub;
            4'd7:    r = 32'd65535 - ua;
            4'd9:    r = (ua * (32'd1 << s)) % 32'd65536;
            4'd10:   r = ua / (32'd1 << s);
            default: r = ua;
        endcase
        return 16'(r);
    endfunction

    // Model state: async clear, writes and SUB flag use pre-edge operands
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) mreg[i] <= 16'd0;
            mzf <= 1'b0;
        end else begin
            if (bus.write_enable && bus.opcode == 4'd3)
                mzf <= (model_alu(4'd3, mreg[bus.address_a], mreg[bus.address_b]) == 16'd0);
            if (bus.write_enable)
                mreg[bus.address_a] <= bus.write_data;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT outputs versus model, plus pinned literals
    always @(negedge clk) begin
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] er;
        if (cmp_en) begin
            ea = mreg[bus.address_a];
            eb = mreg[bus.address_b];
            er = model_alu(bus.opcode, ea, eb);
            check("data_a", bus.data_a, ea);
            check("data_b", bus.data_b, eb);
            check("alu_result", bus.alu_result, er);
            check("alu_zero", {15'd0, bus.alu_zero}, {15'd0, (er == 16'd0)});
            check("zero_flag", {15'd0, bus.zero_flag}, {15'd0, mzf});
            if (lit_valid) begin
                case (lit_kind)
                    K_A:     check(lit_name, bus.data_a, lit_val);
                    K_B:     check(lit_name, bus.data_b, lit_val);
                    K_R:     check(lit_name, bus.alu_result, lit_val);
                    K_Z:     check(lit_name, {15'd0, bus.alu_zero}, lit_val);
                    default: check(lit_name, {15'd0, bus.zero_flag}, lit_val);
                endcase
            end
        end
    end

    // Apply one cycle of inputs just after a rising edge; hold until the next
    task automatic step(input logic [2:0] aa, input logic [2:0] ab, input logic we,
                        input logic [15:0] wd, input logic [3:0] op,
                        input int kind = K_NONE, input logic [15:0] val = 16'd0,
                        input string name = "");
        bus.address_a    = aa;
        bus.address_b    = ab;
        bus.write_enable = we;
        bus.write_data   = wd;
        bus.opcode       = op;
        lit_valid        = (kind != K_NONE);
        lit_kind         = kind;
        lit_val          = val;
        lit_name         = name;
        @(posedge clk);
        #1;
        lit_valid = 1'b0;
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.address_a    = 3'd0;
        bus.address_b    = 3'd0;
        bus.write_enable = 1'b0;
        bus.write_data   = 16'd0;
        bus.opcode       = 4'd0;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;

        // Reset: writes blocked, registers read zero, async clear
        step(3'd3, 3'd3, 1'b1, 16'h1234, 4'd0, K_A, 16'h0000, "reset_read_r3");
        step(3'd3, 3'd3, 1'b1, 16'h1234, 4'd0, K_F, 16'h0000, "reset_flag");
        rst_n = 1'b1;
        step(3'd3, 3'd3, 1'b0, 16'h0000, 4'd0, K_A, 16'h0000, "write_lost_r3");
        step(3'd3, 3'd3, 1'b1, 16'h1234, 4'd0);
        step(3'd3, 3'd3, 1'b0, 16'h0000, 4'd0, K_A, 16'h1234, "r3_written");
        rst_n = 1'b0;
        step(3'd3, 3'd3, 1'b0, 16'h0000, 4'd0, K_A, 16'h0000, "async_clear");
        rst_n = 1'b1;

        // Write / read
        step(3'd1, 3'd0, 1'b1, 16'd5, 4'd0);
        step(3'd2, 3'd0, 1'b1, 16'd3, 4'd0);
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd0, K_A, 16'd5, "read_a_r1");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd0, K_B, 16'd3, "read_b_r2");
        step(3'd7, 3'd0, 1'b1, 16'hFFFF, 4'd0);
        step(3'd7, 3'd7, 1'b0, 16'd0, 4'd0, K_A, 16'hFFFF, "r7_port_a");
        step(3'd7, 3'd7, 1'b0, 16'd0, 4'd0, K_B, 16'hFFFF, "r7_port_b");

        // ADD wrap with write-back, flag untouched
        step(3'd1, 3'd0, 1'b1, 16'hFFFF, 4'd0);
        step(3'd2, 3'd0, 1'b1, 16'd2, 4'd0);
        step(3'd1, 3'd2, 1'b1, 16'h0001, 4'd2, K_R, 16'h0001, "add_wrap");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd0, K_A, 16'h0001, "add_writeback");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd0, K_F, 16'h0000, "add_flag_hold");

        // SUB sets then clears the flag
        step(3'd1, 3'd0, 1'b1, 16'd7, 4'd0);
        step(3'd2, 3'd0, 1'b1, 16'd7, 4'd0);
        step(3'd1, 3'd2, 1'b1, 16'd0, 4'd3, K_Z, 16'h0001, "sub_alu_zero");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd0, K_F, 16'h0001, "sub_flag_set");
        step(3'd2, 3'd0, 1'b1, 16'd1, 4'd0);
        step(3'd1, 3'd2, 1'b1, 16'hFFFF, 4'd3, K_R, 16'hFFFF, "sub_borrow");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd0, K_F, 16'h0000, "sub_flag_clr");

        // Flag hold through ADD-to-zero and non-writing SUB
        step(3'd1, 3'd0, 1'b1, 16'd7, 4'd0);
        step(3'd2, 3'd0, 1'b1, 16'd7, 4'd0);
        step(3'd1, 3'd2, 1'b1, 16'd0, 4'd3);
        step(3'd2, 3'd0, 1'b1, 16'd0, 4'd0);
        step(3'd1, 3'd2, 1'b1, 16'd0, 4'd2, K_Z, 16'h0001, "add_to_zero");
        step(3'd2, 3'd0, 1'b1, 16'd1, 4'd0, K_F, 16'h0001, "flag_after_add");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd3, K_R, 16'hFFFF, "sub_no_we");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd0, K_F, 16'h0001, "flag_held");

        // Logic, shift and pass-through on a=00F0, b=0F0F
        step(3'd1, 3'd0, 1'b1, 16'h00F0, 4'd0);
        step(3'd2, 3'd0, 1'b1, 16'h0F0F, 4'd0);
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd4,  K_R, 16'h0000, "and");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd5,  K_R, 16'h0FFF, "or");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd6,  K_R, 16'h0FFF, "xor");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd7,  K_R, 16'hFF0F, "not");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd9,  K_R, 16'h0000, "shl");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd10, K_R, 16'h0000, "shr");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd15, K_R, 16'h00F0, "pass_1111");
        step(3'd1, 3'd2, 1'b0, 16'hDEAD, 4'd0);
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd0, K_A, 16'h00F0, "we0_no_write");
        step(3'd2, 3'd0, 1'b1, 16'h0004, 4'd0);
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd9,  K_R, 16'h0F00, "shl_by_4");
        step(3'd1, 3'd2, 1'b0, 16'd0, 4'd10, K_R, 16'h000F, "shr_by_4");

        // Random traffic with occasional reset pulses
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            step(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535)),
                 4'($urandom_range(0, 15)));
        end
        rst_n = 1'b1;
        step(3'd0, 3'd0, 1'b0, 16'd0, 4'd0);
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
